// File: rtl/gem_csc_lut_pkg.sv
// Shared constants, address field positions and FSM encoding for the GEM-CSC slope LUT.
// GEM_SLOPE_LUT_PARITY_EN adds one even-parity bit to every stored word.
package gem_csc_lut_pkg;

  localparam int DEPTH = 128;
  localparam int ADR_W = 7;
  localparam int DAT_W = 8;

  localparam int ME1A     = 6;
  localparam int EVEN     = 5;
  localparam int LAYER    = 4;
  localparam int BEND_MSB = 3;
  localparam int BEND_LSB = 0;

`ifdef GEM_SLOPE_LUT_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_ACK   = 3'd4
  } lut_state_t;

  function automatic logic even_par(input logic [DAT_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/gem_csc_lut_ram.sv
// Slope LUT storage: one write port and three read-first registered read ports.
// Lookup ports return zero while rd_en is low so nothing stale leaks out during init.
module gem_csc_lut_ram #(
  parameter int ADR_W  = 7,
  parameter int DAT_W  = 8,
  parameter int WORD_W = 8,
  parameter int DEPTH  = 128
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADR_W-1:0]  wadr,
  input  logic [WORD_W-1:0] wword,
  input  logic              rd_en,
  input  logic [ADR_W-1:0]  lk0_adr,
  input  logic [ADR_W-1:0]  lk1_adr,
  output logic [WORD_W-1:0] lk0_word,
  output logic [WORD_W-1:0] lk1_word,
  input  logic              vme_re,
  input  logic [ADR_W-1:0]  vme_adr,
  output logic [DAT_W-1:0]  vme_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[wadr] <= wword;
  end

  // Non-blocking reads of mem give read-first behaviour against a same-cycle write.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      lk0_word <= '0;
      lk1_word <= '0;
      vme_data <= '0;
    end else begin
      lk0_word <= rd_en ? mem[lk0_adr] : '0;
      lk1_word <= rd_en ? mem[lk1_adr] : '0;
      if (vme_re) vme_data <= mem[vme_adr][DAT_W-1:0];
    end
  end

endmodule

// File: rtl/gem_csc_slope_lut_loader.sv
// Runtime-loadable GEM-CSC slope offset table with VME 4-phase access and two CLCT lookups.
// Optional GEM_SLOPE_LUT_PARITY_EN: stored parity, sticky lookup parity error and capture.
module gem_csc_slope_lut_loader
  import gem_csc_lut_pkg::*;
#(
  parameter int MXADRB = 7,
  parameter int MXDATB = 8,
  parameter int DEPTH  = 128
) (
  input  logic              clock,
  input  logic              global_reset_n,
  input  logic              vme_wr_req,
  input  logic              vme_rd_req,
  input  logic [MXADRB-1:0] vme_adr,
  input  logic [MXDATB-1:0] vme_wdata,
  output logic [MXDATB-1:0] vme_rdata,
  output logic              vme_ack,
  input  logic              clr_req,
  output logic              lut_ready,
  input  logic [MXADRB-1:0] lk0_adr,
  input  logic [MXADRB-1:0] lk1_adr,
  output logic [MXDATB-1:0] lk0_data,
  output logic [MXDATB-1:0] lk1_data,
  output logic              parity_err,
  output logic [MXADRB-1:0] parity_err_adr,
  input  logic              par_inject
);

  localparam int WORD_W = MXDATB + PAR_W;
  localparam logic [MXADRB-1:0] LAST_ADR = MXADRB'(DEPTH - 1);

  lut_state_t        state, state_next;
  logic [MXADRB-1:0] init_cnt;
  logic [MXADRB-1:0] adr_q;
  logic [MXDATB-1:0] wdata_q;
  logic              ack_next;
  logic              any_req;
  logic              ram_we;
  logic              vme_re;
  logic [MXADRB-1:0] ram_wadr;
  logic [MXDATB-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_wword;
  logic [WORD_W-1:0] lk0_word, lk1_word;

  assign any_req   = vme_wr_req | vme_rd_req;
  assign lut_ready = (state != ST_INIT);

  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      adr_q    <= '0;
      wdata_q  <= '0;
      vme_ack  <= 1'b0;
    end else begin
      state   <= state_next;
      vme_ack <= ack_next;
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
      else if (state == ST_IDLE && clr_req) init_cnt <= '0;
      if (state == ST_IDLE) begin
        adr_q   <= vme_adr;
        wdata_q <= vme_wdata;
      end
    end
  end

  // Requests in IDLE are latched into adr_q/wdata_q on the same edge that leaves IDLE.
  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_wadr   = adr_q;
    ram_wdata  = wdata_q;
    vme_re     = 1'b0;
    ack_next   = 1'b0;
    case (state)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_wadr  = init_cnt;
        ram_wdata = '0;
        if (init_cnt == LAST_ADR) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (clr_req)         state_next = ST_INIT;
        else if (vme_wr_req) state_next = ST_WRITE;
        else if (vme_rd_req) state_next = ST_READ;
      end
      ST_WRITE: begin
        ram_we     = 1'b1;
        ack_next   = any_req;
        state_next = ST_ACK;
      end
      ST_READ: begin
        vme_re     = 1'b1;
        ack_next   = any_req;
        state_next = ST_ACK;
      end
      ST_ACK: begin
        if (any_req) ack_next = 1'b1;
        else         state_next = ST_IDLE;
      end
      default: state_next = ST_INIT;
    endcase
  end

`ifdef GEM_SLOPE_LUT_PARITY_EN
  assign ram_wword = {even_par(ram_wdata) ^ (par_inject & (state == ST_WRITE)), ram_wdata};
`else
  logic unused_par_inject;
  assign unused_par_inject = par_inject;
  assign ram_wword = ram_wdata;
`endif

  gem_csc_lut_ram #(
    .ADR_W  (MXADRB),
    .DAT_W  (MXDATB),
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clock    (clock),
    .rst_n    (global_reset_n),
    .we       (ram_we),
    .wadr     (ram_wadr),
    .wword    (ram_wword),
    .rd_en    (lut_ready),
    .lk0_adr  (lk0_adr),
    .lk1_adr  (lk1_adr),
    .lk0_word (lk0_word),
    .lk1_word (lk1_word),
    .vme_re   (vme_re),
    .vme_adr  (adr_q),
    .vme_data (vme_rdata)
  );

  assign lk0_data = lut_ready ? lk0_word[MXDATB-1:0] : '0;
  assign lk1_data = lut_ready ? lk1_word[MXDATB-1:0] : '0;

`ifdef GEM_SLOPE_LUT_PARITY_EN
  logic [MXADRB-1:0] lk0_adr_q, lk1_adr_q;

  // Words are checked the clock after they appear; only the first bad address is kept.
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      lk0_adr_q      <= '0;
      lk1_adr_q      <= '0;
      parity_err     <= 1'b0;
      parity_err_adr <= '0;
    end else begin
      lk0_adr_q <= lk0_adr;
      lk1_adr_q <= lk1_adr;
      if (state == ST_INIT) begin
        parity_err     <= 1'b0;
        parity_err_adr <= '0;
      end else if (!parity_err) begin
        if (^lk0_word) begin
          parity_err     <= 1'b1;
          parity_err_adr <= lk0_adr_q;
        end else if (^lk1_word) begin
          parity_err     <= 1'b1;
          parity_err_adr <= lk1_adr_q;
        end
      end
    end
  end
`else
  assign parity_err     = 1'b0;
  assign parity_err_adr = '0;
`endif

endmodule

// File: tb/tb_gem_csc_slope_lut_loader.sv
// Directed self-checking bench for gem_csc_slope_lut_loader (both GEM_SLOPE_LUT_PARITY_EN builds).
module tb_gem_csc_slope_lut_loader;

  logic       clock = 1'b0;
  logic       global_reset_n;
  logic       vme_wr_req, vme_rd_req;
  logic [6:0] vme_adr;
  logic [7:0] vme_wdata;
  logic [7:0] vme_rdata;
  logic       vme_ack;
  logic       clr_req;
  logic       lut_ready;
  logic [6:0] lk0_adr, lk1_adr;
  logic [7:0] lk0_data, lk1_data;
  logic       parity_err;
  logic [6:0] parity_err_adr;
  logic       par_inject;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  gem_csc_slope_lut_loader dut (
    .clock          (clock),
    .global_reset_n (global_reset_n),
    .vme_wr_req     (vme_wr_req),
    .vme_rd_req     (vme_rd_req),
    .vme_adr        (vme_adr),
    .vme_wdata      (vme_wdata),
    .vme_rdata      (vme_rdata),
    .vme_ack        (vme_ack),
    .clr_req        (clr_req),
    .lut_ready      (lut_ready),
    .lk0_adr        (lk0_adr),
    .lk1_adr        (lk1_adr),
    .lk0_data       (lk0_data),
    .lk1_data       (lk1_data),
    .parity_err     (parity_err),
    .parity_err_adr (parity_err_adr),
    .par_inject     (par_inject)
  );

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wait_ack(input logic level, input string tag);
    int n;
    n = 0;
    tick();
    while (vme_ack !== level && n < 10) begin
      tick();
      n++;
    end
    if (vme_ack !== level) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: vme_ack=%b expected %b within 10 clocks", tag, vme_ack, level);
    end
  endtask

  task automatic vme_write(input logic [6:0] a, input logic [7:0] d);
    vme_adr    = a;
    vme_wdata  = d;
    vme_wr_req = 1'b1;
    wait_ack(1'b1, "wr_ack_rise");
    vme_wr_req = 1'b0;
    wait_ack(1'b0, "wr_ack_fall");
  endtask

  task automatic test_reset;
    logic exp_ready;
    global_reset_n = 1'b1;
    vme_wr_req = 1'b0;
    vme_rd_req = 1'b0;
    vme_adr    = '0;
    vme_wdata  = '0;
    clr_req    = 1'b0;
    lk0_adr    = '0;
    lk1_adr    = '0;
    par_inject = 1'b0;
    #2 global_reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({lut_ready, vme_ack, vme_rdata, lk0_data, lk1_data, parity_err, parity_err_adr} !== 34'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: rdy=%b ack=%b rdata=%h lk0=%h lk1=%h perr=%b padr=%h expected all 0",
               lut_ready, vme_ack, vme_rdata, lk0_data, lk1_data, parity_err, parity_err_adr);
    end
    lk0_adr = 7'h55;
    global_reset_n = 1'b1;
    for (int k = 1; k <= 128; k++) begin
      tick();
      exp_ready = (k == 128);
      checks++;
      if (lut_ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL init_ready_clk%0d: lut_ready=%b expected %b", k, lut_ready, exp_ready);
      end
    end
    tick();
    checks++;
    if (lk0_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL lk0_after_init: got %h expected 00", lk0_data);
    end
  endtask

  task automatic test_write_ack;
    logic exp_ack;
    vme_adr    = 7'h23;
    vme_wdata  = 8'h1A;
    vme_wr_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp_ack = (i >= 2 && i <= 5);
      checks++;
      if (vme_ack !== exp_ack) begin
        errors++;
        $display("[TB] FAIL write_ack_clk%0d: vme_ack=%b expected %b", i, vme_ack, exp_ack);
      end
      if (i == 5) vme_wr_req = 1'b0;
    end
    lk1_adr = 7'h23;
    tick();
    checks++;
    if (lk1_data !== 8'h1A) begin
      errors++;
      $display("[TB] FAIL lk1_after_write: got %h expected 1a", lk1_data);
    end
  endtask

  task automatic test_read_first;
    vme_write(7'h10, 8'h07);
    vme_adr    = 7'h10;
    vme_wdata  = 8'h09;
    vme_wr_req = 1'b1;
    tick();
    lk0_adr = 7'h10;
    tick();
    checks++;
    if (lk0_data !== 8'h07) begin
      errors++;
      $display("[TB] FAIL read_first_old: lk0_data=%h expected 07", lk0_data);
    end
    tick();
    checks++;
    if (lk0_data !== 8'h09) begin
      errors++;
      $display("[TB] FAIL read_first_new: lk0_data=%h expected 09", lk0_data);
    end
    vme_wr_req = 1'b0;
    wait_ack(1'b0, "rf_wr_ack_fall");
    vme_adr    = 7'h10;
    vme_rd_req = 1'b1;
    tick();
    tick();
    checks++;
    if (vme_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_ack: vme_ack=%b expected 1", vme_ack);
    end
    checks++;
    if (vme_rdata !== 8'h09) begin
      errors++;
      $display("[TB] FAIL readback_10: vme_rdata=%h expected 09", vme_rdata);
    end
    vme_rd_req = 1'b0;
    wait_ack(1'b0, "rd_ack_fall");
  endtask

  task automatic test_both_req_clear;
    logic exp_ready;
    vme_adr    = 7'h01;
    vme_wdata  = 8'hFF;
    vme_wr_req = 1'b1;
    vme_rd_req = 1'b1;
    tick();
    tick();
    checks++;
    if (vme_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL both_ack: vme_ack=%b expected 1", vme_ack);
    end
    lk1_adr    = 7'h01;
    clr_req    = 1'b1;
    vme_wr_req = 1'b0;
    tick();
    checks++;
    if (lk1_data !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL both_written: lk1_data=%h expected ff", lk1_data);
    end
    checks++;
    if (vme_rdata !== 8'h09) begin
      errors++;
      $display("[TB] FAIL both_rdata_held: vme_rdata=%h expected 09", vme_rdata);
    end
    checks++;
    if ({vme_ack, lut_ready} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL clr_deferred_ack: ack=%b ready=%b expected 1 1", vme_ack, lut_ready);
    end
    vme_rd_req = 1'b0;
    tick();
    checks++;
    if ({vme_ack, lut_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL clr_deferred_idle: ack=%b ready=%b expected 0 1", vme_ack, lut_ready);
    end
    tick();
    checks++;
    if (lut_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_enter_init: lut_ready=%b expected 0", lut_ready);
    end
    clr_req = 1'b0;
    for (int k = 1; k <= 128; k++) begin
      tick();
      exp_ready = (k == 128);
      checks++;
      if (lut_ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL clr_init_clk%0d: lut_ready=%b expected %b", k, lut_ready, exp_ready);
      end
    end
    tick();
    checks++;
    if (lk1_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL cleared_lk1: lk1_data=%h expected 00", lk1_data);
    end
    vme_adr    = 7'h01;
    vme_rd_req = 1'b1;
    tick();
    tick();
    checks++;
    if (vme_rdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL cleared_readback: vme_rdata=%h expected 00", vme_rdata);
    end
    vme_rd_req = 1'b0;
    wait_ack(1'b0, "clr_rd_ack_fall");
  endtask

  task automatic test_parity;
    int n;
    par_inject = 1'b1;
    vme_write(7'h4C, 8'h03);
    par_inject = 1'b0;
    lk0_adr = 7'h4C;
    tick();
    checks++;
    if (lk0_data !== 8'h03) begin
      errors++;
      $display("[TB] FAIL par_data: lk0_data=%h expected 03", lk0_data);
    end
    tick();
`ifdef GEM_SLOPE_LUT_PARITY_EN
    checks++;
    if ({parity_err, parity_err_adr} !== {1'b1, 7'h4C}) begin
      errors++;
      $display("[TB] FAIL par_first: err=%b adr=%h expected 1 4c", parity_err, parity_err_adr);
    end
    par_inject = 1'b1;
    vme_write(7'h4D, 8'h05);
    par_inject = 1'b0;
    lk1_adr = 7'h4D;
    tick();
    tick();
    checks++;
    if ({parity_err, parity_err_adr} !== {1'b1, 7'h4C}) begin
      errors++;
      $display("[TB] FAIL par_sticky: err=%b adr=%h expected 1 4c", parity_err, parity_err_adr);
    end
    lk0_adr = 7'h00;
    lk1_adr = 7'h00;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    checks++;
    if ({parity_err, parity_err_adr} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL par_clear: err=%b adr=%h expected 0 00", parity_err, parity_err_adr);
    end
    n = 0;
    while (!lut_ready && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (lut_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL par_reinit: lut_ready=%b expected 1 within 200 clocks", lut_ready);
    end
`else
    n = 0;
    checks++;
    if ({parity_err, parity_err_adr} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL par_disabled: err=%b adr=%h expected 0 00", parity_err, parity_err_adr);
    end
`endif
  endtask

  task automatic test_reset_mid_ack;
    int n;
    vme_adr    = 7'h30;
    vme_wdata  = 8'hAA;
    vme_wr_req = 1'b1;
    tick();
    tick();
    checks++;
    if (vme_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_ack_high: vme_ack=%b expected 1", vme_ack);
    end
    #2 global_reset_n = 1'b0;
    #1;
    checks++;
    if ({vme_ack, lut_ready} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL async_reset: ack=%b ready=%b expected 0 0", vme_ack, lut_ready);
    end
    vme_wr_req = 1'b0;
    lk0_adr    = 7'h30;
    @(negedge clock);
    global_reset_n = 1'b1;
    n = 0;
    while (!lut_ready && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != 128) begin
      errors++;
      $display("[TB] FAIL reinit_len: lut_ready after %0d clocks expected 128", n);
    end
    tick();
    checks++;
    if (lk0_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL write_lost: lk0_data=%h expected 00", lk0_data);
    end
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_read_first();
    test_both_req_clear();
    test_parity();
    test_reset_mid_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gem_csc_slope_lut_loader.md
# gem_csc_slope_lut_loader

Runtime-programmable store for the GEM-CSC slope-correction offsets. It writes, clears and reads back the 128-entry table over a VME-style 4-phase handshake, and serves two registered lookups per clock, one for each CLCT. It replaces the fixed `.mem` slope ROMs feeding the CLCT-to-GEM extrapolation in the pattern finder. The pattern-finder side sees the same interface as before: a bend-indexed address in, an 8-bit offset out, one clock of latency.

## Interface
Parameters:
- `MXADRB`, 7: table address width, {isME1a, even, layer2, bend[3:0]}.
- `MXDATB`, 8: offset width in half-strips.
- `DEPTH`, 128: number of entries; must equal 2**MXADRB.

Ports:
- `clock`  in  1  main clock.
- `global_reset_n`  in  1  reset, asynchronous, active-low.
- `vme_wr_req`  in  1  write request, 4-phase.
- `vme_rd_req`  in  1  readback request, 4-phase.
- `vme_adr`  in  7  VME table address.
- `vme_wdata`  in  8  write data.
- `vme_rdata`  out  8  readback data; valid while `vme_ack`=1.
- `vme_ack`  out  1  handshake acknowledge.
- `clr_req`  in  1  level; requests a full table clear.
- `lut_ready`  out  1  table initialised and lookups valid.
- `lk0_adr`, `lk1_adr`  in  7  lookup addresses for clct0 and clct1.
- `lk0_data`, `lk1_data`  out  8  registered lookup offsets.
- `parity_err`  out  1  sticky lookup parity error (macro only; otherwise tied 0).
- `parity_err_adr`  out  7  address of the first parity error (macro only; otherwise 0).
- `par_inject`  in  1  inverts the stored parity of the next write (macro only).

## Operation
- FSM states: INIT, IDLE, WRITE, READ, ACK.
- **INIT**
  - A 7-bit counter writes 0, with correct parity, to addresses 0..127, one per clock.
  - On count 127 the FSM goes to IDLE and `lut_ready` rises.
- **IDLE priority**: `clr_req` > `vme_wr_req` > `vme_rd_req`.
  - `clr_req` clears the counter and enters INIT.
  - Write request: enter WRITE. Read request: enter READ.
- **WRITE**
  - One RAM write of `vme_wdata` to `vme_adr`, both sampled on entry.
  - Then go to ACK.
- **READ**
  - Registers RAM[`vme_adr`] into `vme_rdata`. Then go to ACK.
- **ACK**
  - `vme_ack`=1 while either request is high.
  - When both requests are low, `vme_ack`=0 and the FSM returns to IDLE.
  - `vme_rdata` holds until the next READ.
- **Both requests high in IDLE**: only the write is performed; ACK waits for both requests to drop.
- **`clr_req` during WRITE, READ or ACK**: deferred until IDLE. `clr_req` in INIT is ignored; the counter does not restart.
- **Lookups**
  - Registered, read-first.
  - A lookup to the address being written in the same cycle returns the old value.
  - `lk*_data` is forced to 0 while `lut_ready`=0.

## Timing
- Reset values:
  - state INIT, counter 0.
  - `lut_ready`, `vme_ack`, `vme_rdata`, `lk0_data`, `lk1_data`, `parity_err`, `parity_err_adr` all 0.
- After `global_reset_n` rises: 128 clocks of INIT; `lut_ready`=1 on clock 129.
- Write:
  - Request sampled at edge N; RAM written at N+1.
  - `vme_ack` high from N+2 while the request is high; falls 1 clock after the request drops.
- Read: `vme_rdata` valid with `vme_ack`, at N+2.
- Lookup latency: 1 clock, address at N → data at N+1. Two independent ports.
- Reset mid-transaction: `vme_ack` drops immediately, the write is lost, and INIT restarts.

## Configuration
- `GEM_SLOPE_LUT_PARITY_EN` defined:
  - RAM is 9 bits wide; bit 8 is the even parity of the data.
  - Each lookup output is checked one clock after the data appears.
  - A mismatch when `lut_ready`=1 sets `parity_err`, sticky. The first failing address is captured in `parity_err_adr`.
  - Both are cleared by reset or by entering INIT.
  - `par_inject` sampled high in WRITE stores inverted parity.
- Macro undefined:
  - RAM is 8 bits wide.
  - `parity_err`=0, `parity_err_adr`=0, `par_inject` ignored.

## Structure
- Package `gem_csc_lut_pkg`:
  - DEPTH.
  - Address field positions: ME1A=6, EVEN=5, LAYER=4, BEND=3:0.
  - FSM state encoding.
- Sub-module `gem_csc_lut_ram`:
  - DEPTH × (8 or 9) bits, one write port, three read-first registered read ports (lk0, lk1, vme).

## Test plan
- Reset release → `lut_ready`=0 for 128 clocks, 1 on clock 129; `lk0_adr`=7'h55 → `lk0_data`=0.
- Write adr 7'h23 = 8'h1A; hold `vme_wr_req` for 5 clocks → `vme_ack` high 4 clocks, falls 1 clock after req drops; `lk1_adr`=7'h23 → 8'h1A next clock.
- Write 7'h10 = 8'h07, then write 8'h09 to 7'h10 while `lk0_adr`=7'h10 in the write cycle → `lk0_data`=8'h07, then 8'h09 one clock later. Read back 7'h10 → `vme_rdata`=8'h09.
- `vme_wr_req` and `vme_rd_req` both high, adr 7'h01, data 8'hFF → entry written, `vme_rdata` unchanged; `clr_req` asserted during ACK → INIT only after both requests drop; `lut_ready` low for 128 clocks; entry 7'h01 reads 0.
- (`GEM_SLOPE_LUT_PARITY_EN`) write 7'h4C = 8'h03 with `par_inject`=1, then look it up → `parity_err`=1, `parity_err_adr`=7'h4C. A second bad address does not change `parity_err_adr`; `clr_req` clears both.
- Pull `global_reset_n` low during ACK → `vme_ack` drops asynchronously and INIT restarts.
